// File: rtl/axi_burst_arbiter.sv
// axi_burst_arbiter: two-requester round-robin arbiter that expands FIXED/INCR/WRAP bursts
// into a stream of beat addresses and returns a completion pulse to the owning requester.
module axi_burst_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic [1:0]        rq_valid,
  output logic [1:0]        rq_ready,
  input  logic              rq_write0,
  input  logic              rq_write1,
  input  logic [ADDR_W-1:0] rq_addr0,
  input  logic [ADDR_W-1:0] rq_addr1,
  input  logic [LEN_W-1:0]  rq_len0,
  input  logic [LEN_W-1:0]  rq_len1,
  input  logic [2:0]        rq_size0,
  input  logic [2:0]        rq_size1,
  input  logic [1:0]        rq_type0,
  input  logic [1:0]        rq_type1,
  output logic              bt_valid,
  input  logic              bt_ready,
  output logic [ADDR_W-1:0] bt_addr,
  output logic              bt_write,
  output logic              bt_last,
  output logic              bt_owner,
  input  logic              done_in,
  output logic [1:0]        gnt_done,
  output logic              err
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, BEAT = 2'd2, WAIT_DONE = 2'd3;
  localparam logic [1:0] M_FIXED = 2'd0, M_INCR = 2'd1, M_WRAP = 2'd2;
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  logic [1:0] state_q, state_d, mode_q, mode_d, type_q, type_d;
  logic ptr_q, ptr_d, owner_q, owner_d, write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cur_q, cur_d, lo_q, lo_d, bytes_q, bytes_d;
  logic [ADDR_W:0] hi_q, hi_d, nxt;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, last_q, last_d;
  logic [2:0] size_q, size_d;
  logic win, grant, wrap_ok, bad;
  logic [31:0] len32;
  logic [ADDR_W-1:0] bytes, span, base;
  assign win = &rq_valid ? ptr_q : rq_valid[1];
  assign grant = reset && state_q == IDLE && |rq_valid;
  assign len32 = 32'(len_q);
  assign wrap_ok = len32 == 32'd2 || len32 == 32'd4 || len32 == 32'd8 || len32 == 32'd16;
  assign bad = len_q == '0 || type_q == 2'b11 || (type_q == 2'b10 && !wrap_ok);
  assign bytes = ONE << size_q;
  assign span = ADDR_W'(len_q) << size_q;
  assign base = addr_q & ~(span - ONE);
  // one extra bit so a wrap window ending exactly at the top of the address space still compares correctly
  assign nxt = {1'b0, cur_q} + {1'b0, bytes_q};
  assign rq_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign bt_valid = reset && state_q == BEAT;
  assign bt_addr = cur_q;
  assign bt_write = write_q;
  assign bt_owner = owner_q;
  assign bt_last = bt_valid && cnt_q == last_q;
  assign gnt_done = (reset && state_q == WAIT_DONE && done_in) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign err = reset && state_q == LOAD && bad;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d = addr_q;
    len_d = len_q;
    size_d = size_q;
    type_d = type_q;
    mode_d = mode_q;
    cur_d = cur_q;
    lo_d = lo_q;
    hi_d = hi_q;
    bytes_d = bytes_q;
    last_d = last_q;
    cnt_d = cnt_q;
    if (grant) begin
      state_d = LOAD;
      owner_d = win;
      write_d = win ? rq_write1 : rq_write0;
      addr_d = win ? rq_addr1 : rq_addr0;
      len_d = win ? rq_len1 : rq_len0;
      size_d = win ? rq_size1 : rq_size0;
      type_d = win ? rq_type1 : rq_type0;
    end
    if (state_q == LOAD) begin
      state_d = BEAT;
      mode_d = type_q == 2'b00 ? M_FIXED : (type_q == 2'b10 && wrap_ok) ? M_WRAP : M_INCR;
      bytes_d = bytes;
      cur_d = addr_q & ~(bytes - ONE);
      lo_d = base;
      hi_d = {1'b0, base} + {1'b0, span};
      last_d = len_q == '0 ? '0 : len_q - LEN_W'(1);
      cnt_d = '0;
    end
    if (state_q == BEAT && bt_ready) begin
      state_d = cnt_q == last_q ? WAIT_DONE : BEAT;
      cnt_d = cnt_q + LEN_W'(1);
      cur_d = mode_q == M_FIXED ? cur_q : (mode_q == M_WRAP && nxt >= hi_q) ? lo_q : nxt[ADDR_W-1:0];
    end
    if (state_q == WAIT_DONE && done_in) begin
      state_d = IDLE;
      ptr_d = !owner_q;
    end
  end
  always_ff @(posedge aclk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      type_q <= '0;
      mode_q <= M_FIXED;
      cur_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      bytes_q <= '0;
      last_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      type_q <= type_d;
      mode_q <= mode_d;
      cur_q <= cur_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      bytes_q <= bytes_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axi_burst_arbiter.sv
// tb_axi_burst_arbiter: directed vector table, hand-written reset/arbitration sequences and
// randomized bursts checked against an arithmetic address/arbitration model.
module tb_axi_burst_arbiter;
  logic aclk = 1'b0, reset = 1'b0;
  logic [1:0] rq_valid = '0;
  logic rq_write0 = 1'b0, rq_write1 = 1'b0;
  logic [31:0] rq_addr0 = '0, rq_addr1 = '0;
  logic [5:0] rq_len0 = '0, rq_len1 = '0;
  logic [2:0] rq_size0 = '0, rq_size1 = '0;
  logic [1:0] rq_type0 = '0, rq_type1 = '0;
  logic bt_ready = 1'b0, done_in = 1'b0;
  logic [1:0] rq_ready, gnt_done;
  logic bt_valid, bt_write, bt_last, bt_owner, err;
  logic [31:0] bt_addr;
  axi_burst_arbiter dut (
    .aclk(aclk), .reset(reset), .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq_write0(rq_write0), .rq_write1(rq_write1), .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
    .rq_len0(rq_len0), .rq_len1(rq_len1), .rq_size0(rq_size0), .rq_size1(rq_size1),
    .rq_type0(rq_type0), .rq_type1(rq_type1), .bt_valid(bt_valid), .bt_ready(bt_ready),
    .bt_addr(bt_addr), .bt_write(bt_write), .bt_last(bt_last), .bt_owner(bt_owner),
    .done_in(done_in), .gnt_done(gnt_done), .err(err)
  );
  always #5 aclk = ~aclk;
  typedef struct {
    int req;
    logic wr;
    logic [31:0] a;
    logic [5:0] l;
    logic [2:0] s;
    logic [1:0] t;
    logic e;
    int n;
    logic [0:3][31:0] x;
  } vec_t;
  vec_t tbl [6];
  int n_cmp = 0, n_bad = 0;
  logic ptr_m = 1'b0;
  logic pend [2];
  logic f_w [2];
  logic [31:0] f_a [2];
  logic [5:0] f_l [2];
  logic [2:0] f_s [2];
  logic [1:0] f_t [2];
  logic [31:0] got [$];
  logic seen_err;
  int last_w;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic wrap_len(input logic [5:0] l);
    return l == 6'd2 || l == 6'd4 || l == 6'd8 || l == 6'd16;
  endfunction
  function automatic logic is_bad(input logic [5:0] l, input logic [1:0] t);
    return l == 6'd0 || t == 2'b11 || (t == 2'b10 && !wrap_len(l));
  endfunction
  // Beat i address from the burst rules: aligned start, then offset within a span window for WRAP
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [5:0] l,
                                           input logic [2:0] s, input logic [1:0] t, input int i);
    longint by, al, sp, bs, r;
    by = longint'(1) << s;
    al = (longint'(a) / by) * by;
    if (t == 2'b00) r = al;
    else if (t == 2'b10 && wrap_len(l)) begin
      sp = longint'(l) * by;
      bs = (longint'(a) / sp) * sp;
      r = bs + (al - bs + longint'(i) * by) % sp;
    end else r = al + longint'(i) * by;
    return r[31:0];
  endfunction
  task automatic drive();
    rq_valid = {pend[1], pend[0]};
    rq_write0 = f_w[0]; rq_write1 = f_w[1];
    rq_addr0 = f_a[0]; rq_addr1 = f_a[1];
    rq_len0 = f_l[0]; rq_len1 = f_l[1];
    rq_size0 = f_s[0]; rq_size1 = f_s[1];
    rq_type0 = f_t[0]; rq_type1 = f_t[1];
  endtask
  task automatic set_req(input int r, input logic wr, input logic [31:0] a, input logic [5:0] l,
                         input logic [2:0] s, input logic [1:0] t);
    pend[r] = 1'b1; f_w[r] = wr; f_a[r] = a; f_l[r] = l; f_s[r] = s; f_t[r] = t;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_rq_ready"}, rq_ready, 0);
    chk({tag, "_bt_valid"}, bt_valid, 0);
    chk({tag, "_bt_addr"}, bt_addr, 0);
    chk({tag, "_bt_write"}, bt_write, 0);
    chk({tag, "_bt_last"}, bt_last, 0);
    chk({tag, "_bt_owner"}, bt_owner, 0);
    chk({tag, "_gnt_done"}, gnt_done, 0);
    chk({tag, "_err"}, err, 0);
  endtask
  // Grant one pending request and run its burst to completion, checking every cycle
  task automatic serve(input bit rnd);
    int w, n, i, cyc, k;
    logic cw;
    logic [31:0] ca;
    logic [5:0] cl;
    logic [2:0] cs;
    logic [1:0] ct;
    @(negedge aclk);
    done_in = 1'b0; bt_ready = 1'b0; drive(); #1;
    w = (pend[0] && pend[1]) ? int'(ptr_m) : (pend[1] ? 1 : 0);
    last_w = w;
    chk("rq_ready_grant", rq_ready, w == 1 ? 2'b10 : 2'b01);
    cw = f_w[w]; ca = f_a[w]; cl = f_l[w]; cs = f_s[w]; ct = f_t[w];
    @(negedge aclk);
    pend[w] = 1'b0; f_w[w] = ~cw; f_a[w] = $urandom; f_l[w] = 6'($urandom); f_s[w] = 3'($urandom);
    f_t[w] = 2'($urandom); drive(); #1;
    seen_err = err;
    chk("err_load", err, is_bad(cl, ct));
    chk("rq_ready_load", rq_ready, 0);
    chk("bt_valid_load", bt_valid, 0);
    n = cl == 6'd0 ? 1 : int'(cl); i = 0; cyc = 0; got.delete();
    while (i < n && cyc < 400) begin
      @(negedge aclk);
      bt_ready = rnd ? 1'($urandom) : 1'b1;
      done_in = rnd ? 1'($urandom) : 1'b0;
      #1;
      chk("bt_valid", bt_valid, 1);
      chk("bt_addr", bt_addr, exp_addr(ca, cl, cs, ct, i));
      chk("bt_last", bt_last, i == n - 1);
      chk("bt_owner", bt_owner, w);
      chk("bt_write", bt_write, cw);
      chk("gnt_done_beat", gnt_done, 0);
      chk("rq_ready_beat", rq_ready, 0);
      if (bt_ready) begin
        got.push_back(bt_addr);
        i++;
      end
      cyc++;
    end
    if (i < n) chk("beat_timeout", i, n);
    k = rnd ? $urandom_range(0, 3) : 0;
    for (int j = 0; j <= k; j++) begin
      @(negedge aclk);
      done_in = 1'b0; bt_ready = 1'($urandom); #1;
      chk("bt_valid_wait", bt_valid, 0);
      chk("gnt_done_wait", gnt_done, 0);
    end
    @(negedge aclk);
    done_in = 1'b1; #1;
    chk("gnt_done", gnt_done, w == 1 ? 2'b10 : 2'b01);
    ptr_m = !w[0];
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{0, 1'b0, 32'h65, 6'd4, 3'd2, 2'b01, 1'b0, 4, '{32'h64, 32'h68, 32'h6C, 32'h70}};
    tbl[1] = '{1, 1'b0, 32'h68, 6'd4, 3'd2, 2'b10, 1'b0, 4, '{32'h68, 32'h6C, 32'h60, 32'h64}};
    tbl[2] = '{0, 1'b1, 32'h67, 6'd3, 3'd2, 2'b00, 1'b0, 3, '{32'h64, 32'h64, 32'h64, 32'h0}};
    tbl[3] = '{1, 1'b0, 32'h40, 6'd0, 3'd3, 2'b10, 1'b1, 1, '{32'h40, 32'h0, 32'h0, 32'h0}};
    tbl[4] = '{0, 1'b1, 32'h13, 6'd2, 3'd0, 2'b11, 1'b1, 2, '{32'h13, 32'h14, 32'h0, 32'h0}};
    tbl[5] = '{1, 1'b1, 32'hFFFF_FFF8, 6'd4, 3'd2, 2'b10, 1'b0, 4,
               '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF4}};
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; f_w[r] = 1'b0; f_a[r] = '0; f_l[r] = '0; f_s[r] = '0; f_t[r] = '0;
    end
    repeat (2) @(posedge aclk);
    @(negedge aclk); #1;
    chk_zero("reset");
    reset = 1'b1;
    for (int v = 0; v < 6; v++) begin
      set_req(tbl[v].req, tbl[v].wr, tbl[v].a, tbl[v].l, tbl[v].s, tbl[v].t);
      serve(1'b0);
      chk("tbl_owner", last_w, tbl[v].req);
      chk("tbl_err", seen_err, tbl[v].e);
      chk("tbl_beats", got.size(), tbl[v].n);
      for (int j = 0; j < tbl[v].n && j < got.size(); j++) chk("tbl_addr", got[j], tbl[v].x[j]);
    end
    for (int b = 0; b < 4; b++) begin
      if (!pend[0]) set_req(0, 1'b0, 32'h200 + 32'(b * 64), 6'd2, 3'd2, 2'b01);
      if (!pend[1]) set_req(1, 1'b1, 32'h800 + 32'(b * 64), 6'd3, 3'd1, 2'b01);
      serve(1'b0);
      chk("grant_order", last_w, b % 2);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    set_req(0, 1'b0, 32'h1000, 6'd6, 3'd3, 2'b01);
    serve(1'b1);
    chk("stall_beats", got.size(), 6);
    for (int j = 0; j < 6 && j < got.size(); j++) chk("stall_addr", got[j], 32'h1000 + 32'(j * 8));
    for (int r = 0; r < 40; r++) begin
      for (int q = 0; q < 2; q++)
        if (!pend[q] && $urandom_range(0, 2) != 0)
          set_req(q, 1'($urandom), $urandom, ($urandom_range(0, 4) == 0) ? 6'd16 : 6'($urandom_range(0, 9)),
                  3'($urandom), 2'($urandom));
      if (!pend[0] && !pend[1]) set_req($urandom_range(0, 1), 1'b0, $urandom, 6'd4, 3'd1, 2'b10);
      serve(1'b1);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    set_req(0, 1'b0, 32'h300, 6'd1, 3'd0, 2'b01);
    serve(1'b0);
    @(negedge aclk);
    done_in = 1'b0; bt_ready = 1'b0;
    set_req(1, 1'b1, 32'h100, 6'd3, 3'd2, 2'b10);
    drive(); #1;
    chk("rst_seq_grant", rq_ready, 2'b10);
    @(negedge aclk);
    pend[1] = 1'b0; drive(); #1;
    chk("rst_seq_err", err, 1);
    @(negedge aclk);
    bt_ready = 1'b1; #1;
    chk("rst_seq_addr0", bt_addr, 32'h100);
    @(negedge aclk); #1;
    chk("rst_seq_addr1", bt_addr, 32'h104);
    chk("rst_seq_owner", bt_owner, 1);
    reset = 1'b0; done_in = 1'b1; #1;
    chk("rst_seq_no_done", gnt_done, 0);
    @(negedge aclk); #1;
    chk_zero("midreset");
    @(negedge aclk); #1;
    chk("midreset_no_done", gnt_done, 0);
    reset = 1'b1; done_in = 1'b0; bt_ready = 1'b0;
    ptr_m = 1'b0;
    set_req(0, 1'b0, 32'h400, 6'd2, 3'd2, 2'b01);
    set_req(1, 1'b1, 32'h500, 6'd2, 3'd2, 2'b01);
    serve(1'b0);
    chk("post_reset_winner", last_w, 0);
    serve(1'b0);
    chk("post_reset_pending", last_w, 1);
    @(negedge aclk);
    done_in = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_burst_arbiter.md
AXI_BURST_ARBITER -- requirements
Module: axi_burst_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of requester and beat ports.
REQ-002 Parameter: LEN_W, default 6, burst-length field width (beats 1..2^LEN_W-1).
REQ-003 aclk  input  1  clock; all logic on posedge aclk.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 rq_valid  input  2  per-requester burst request valid; bit n = requester n.
REQ-006 rq_ready  output  2  per-requester request accept; one-hot or zero.
REQ-007 rq_write0/rq_write1  input  1 each  1 = write burst, 0 = read burst.
REQ-008 rq_addr0/rq_addr1  input  ADDR_W each  burst start address in bytes.
REQ-009 rq_len0/rq_len1  input  LEN_W each  beat count.
REQ-010 rq_size0/rq_size1  input  3 each  log2 bytes per beat (0..7).
REQ-011 rq_type0/rq_type1  input  2 each  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-012 bt_valid  output  1  beat command valid.
REQ-013 bt_ready  input  1  downstream accepts beat.
REQ-014 bt_addr  output  ADDR_W  beat address.
REQ-015 bt_write  output  1  direction of current burst.
REQ-016 bt_last  output  1  final beat of burst.
REQ-017 bt_owner  output  1  index of granted requester.
REQ-018 done_in  input  1  downstream completion pulse (write response or read last).
REQ-019 gnt_done  output  2  one-cycle completion pulse to owning requester.
REQ-020 err  output  1  one-cycle pulse on illegal request.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, BEAT, WAIT_DONE.
REQ-022 IDLE: any rq_valid bit set -> assert rq_ready for winner that cycle, capture its fields, go LOAD next cycle.
REQ-023 Arbitration SHALL be round-robin; priority pointer initialised to requester 0 and moved to the non-winner when the burst completes.
REQ-024 Both valid in the same cycle -> pointer holder wins; loser stays pending (rq_ready low) with no loss.
REQ-025 LOAD (one cycle): compute bytes = 1<<size, aligned = addr with low size bits cleared, wrap span = len*bytes, wrap base = addr rounded down to span multiple; beat counter = 0.
REQ-026 BEAT: bt_valid=1; beat advances only on bt_valid & bt_ready; bt_addr held stable while stalled.
REQ-027 FIXED: every beat address = aligned.
REQ-028 INCR: beat i address = aligned + i*bytes, modulo 2^ADDR_W.
REQ-029 WRAP: first beat = aligned; next = previous + bytes, replaced by wrap base when result >= base + span.
REQ-030 bt_last=1 exactly when beat counter = len-1 with bt_valid high.
REQ-031 Final beat accepted -> go WAIT_DONE, bt_valid=0 next cycle.
REQ-032 WAIT_DONE: on done_in=1 -> pulse gnt_done[owner] one cycle, update pointer, go IDLE; done_in in any other state ignored.
REQ-033 len=0 SHALL execute as 1 beat and pulse err in LOAD.
REQ-034 type 11 SHALL execute as INCR and pulse err in LOAD.
REQ-035 WRAP with len not in {2,4,8,16} SHALL execute as INCR and pulse err in LOAD.
REQ-036 Requester fields SHALL be sampled only in the rq_ready cycle; later changes have no effect on the active burst.
REQ-037 No new grant while not IDLE; rq_ready=0 in LOAD, BEAT, WAIT_DONE.

Reset
REQ-038 reset=0 at a clock edge -> state IDLE, pointer 0, beat counter 0, all outputs 0 (rq_ready, bt_valid, bt_addr, bt_write, bt_last, bt_owner, gnt_done, err).
REQ-039 Reset mid-burst SHALL abandon the burst with no gnt_done pulse; pending requests re-arbitrate after release.

Verification
REQ-040 Req0 INCR, addr 0x65, size 2, len 4, bt_ready=1 -> bt_addr 0x64,0x68,0x6C,0x70; bt_last on 4th beat; gnt_done[0] after done_in.
REQ-041 Req1 WRAP, addr 0x68, size 2, len 4 -> bt_addr 0x68,0x6C,0x60,0x64; bt_last on 0x64.
REQ-042 Req0 FIXED, addr 0x67, size 2, len 3 -> three beats at 0x64, bt_last on 3rd.
REQ-043 Both requests held valid for 4 bursts -> grant order 0,1,0,1; no request dropped.
REQ-044 bt_ready toggled 0/1 during INCR burst -> bt_addr stable while stalled, beat count unchanged, exactly len accepted beats.
REQ-045 WRAP len 3 -> err pulse, INCR addresses; reset asserted during 2nd beat -> all outputs 0, no gnt_done.
